// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller: FSM states, corner
// operand pairs, LFSR tap mask and error-counter helpers.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Fixed corner vectors issued as indices 0..3 of every run.
    localparam logic [15:0] CORNER_A0 = 16'h0000;
    localparam logic [15:0] CORNER_B0 = 16'h0000;
    localparam logic [15:0] CORNER_A1 = 16'hFFFF;
    localparam logic [15:0] CORNER_B1 = 16'hFFFF;
    localparam logic [15:0] CORNER_A2 = 16'hFFFF;
    localparam logic [15:0] CORNER_B2 = 16'h0001;
    localparam logic [15:0] CORNER_A3 = 16'h8000;
    localparam logic [15:0] CORNER_B3 = 16'h8000;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [15:0] ERR_SAT     = 16'hFFFF;
    localparam logic [15:0] NO_FAIL_IDX = 16'hFFFF;

    // Corner operand pair packed as {a, b}.
    function automatic logic [31:0] corner_pair(input logic [1:0] idx);
        logic [31:0] pair;
        case (idx)
            2'd0:    pair = {CORNER_A0, CORNER_B0};
            2'd1:    pair = {CORNER_A1, CORNER_B1};
            2'd2:    pair = {CORNER_A2, CORNER_B2};
            2'd3:    pair = {CORNER_A3, CORNER_B3};
            default: pair = 32'h0000_0000;
        endcase
        return pair;
    endfunction

    // One right-shifting Galois step.
    function automatic logic [31:0] galois_step(input logic [31:0] s);
        return (s >> 1) ^ ({32{s[0]}} & LFSR_TAPS);
    endfunction

    // Error counter increment that sticks at the ceiling.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == ERR_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/adder_bist_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
import adder_bist_pkg::*;

module lfsr32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [31:0] i_seed,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    // Seed on reset or load request, otherwise step when enabled.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= galois_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/adder_bist.sv
// BIST initiator/checker for the registered adder: issues corner and
// pseudo-random operand pairs, predicts the sums and compares them after
// the adder's pipeline latency.
import adder_bist_pkg::*;

module adder_bist #(
    parameter int          WIDTH       = 16,
    parameter int          LATENCY     = 2,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_1234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH:0]   sum_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_fail_idx
);

    localparam logic [31:0] LOAD_SEED  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  LAST_DRAIN = 8'(LATENCY - 1);

    state_t      r_state;
    logic [15:0] r_idx;
    logic [7:0]  r_drain;

    logic [WIDTH:0]     r_exp  [LATENCY];
    logic [15:0]        r_didx [LATENCY];
    logic [LATENCY-1:0] r_vld;

    logic        w_start_run;
    logic [15:0] w_next_idx;
    logic [15:0] w_sel_idx;
    logic        w_issue_rand;
    logic [31:0] w_lfsr;
    logic [31:0] w_pair;
    logic        w_mismatch;
    logic        w_first;
    logic [15:0] w_err_next;

    assign w_start_run  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_next_idx   = r_idx + 16'd1;
    assign w_sel_idx    = w_start_run ? 16'd0 : w_next_idx;
    // The LFSR steps exactly when its current state is consumed as a vector.
    assign w_issue_rand = (r_state == ST_RUN) && (r_idx != LAST_IDX) && (w_next_idx >= 16'd4);

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_start_run),
        .i_en    (w_issue_rand),
        .i_seed  (LOAD_SEED),
        .o_state (w_lfsr)
    );

    // Pick the operand pair for the vector about to be issued.
    always_comb begin
        w_pair = 32'h0000_0000;
        if (w_sel_idx < 16'd4) begin
            w_pair = corner_pair(w_sel_idx[1:0]);
        end else begin
            w_pair = w_lfsr;
        end
    end

    assign w_mismatch = r_vld[LATENCY-1] && (sum_i != r_exp[LATENCY-1]);
    assign w_err_next = w_mismatch ? sat_inc16(err_cnt) : err_cnt;
    assign w_first    = w_mismatch && (err_cnt == 16'd0);

    // Expected-sum delay line aligned with the adder's pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_exp[i]  <= '0;
                r_didx[i] <= 16'd0;
            end
            r_vld <= '0;
        end else begin
            r_exp[0]  <= {1'b0, a_o} + {1'b0, b_o};
            r_didx[0] <= r_idx;
            r_vld[0]  <= (r_state == ST_RUN);
            for (int i = 1; i < LATENCY; i++) begin
                r_exp[i]  <= r_exp[i-1];
                r_didx[i] <= r_didx[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    // Run sequencing, operand issue and result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= 16'd0;
            r_drain        <= 8'd0;
            a_o            <= '0;
            b_o            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 16'd0;
            first_fail_idx <= NO_FAIL_IDX;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state        <= ST_RUN;
                        r_idx          <= 16'd0;
                        a_o            <= WIDTH'(w_pair[31:16]);
                        b_o            <= WIDTH'(w_pair[15:0]);
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        err_cnt        <= 16'd0;
                        first_fail_idx <= NO_FAIL_IDX;
                    end
                end
                ST_RUN: begin
                    err_cnt <= w_err_next;
                    if (w_first) begin
                        first_fail_idx <= r_didx[LATENCY-1];
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 8'd0;
                        a_o     <= '0;
                        b_o     <= '0;
                    end else begin
                        r_idx <= w_next_idx;
                        a_o   <= WIDTH'(w_pair[31:16]);
                        b_o   <= WIDTH'(w_pair[15:0]);
                    end
                end
                ST_DRAIN: begin
                    err_cnt <= w_err_next;
                    if (w_first) begin
                        first_fail_idx <= r_didx[LATENCY-1];
                    end
                    if (r_drain == LAST_DRAIN) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 16'd0);
                    end else begin
                        r_drain <= r_drain + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist.sv
// Testbench for adder_bist: a behavioural adder with selectable faults
// answers the BIST, and a vector-list reference predicts every cycle.
module tb_adder_bist;

    localparam int NV = 16;
    localparam int L  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_o, b_o;
    logic [16:0] sum_i;
    logic        busy, done, pass;
    logic [15:0] err_cnt, first_fail_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Adder under test: 0 = ideal 2-cycle, 1 = sum bit 16 stuck at 0, 2 = 3-cycle latency.
    int          mode = 0;
    logic [15:0] m_a = 16'h0, m_b = 16'h0;
    logic [16:0] m_s1 = 17'h0, m_s2 = 17'h0;

    logic [15:0] ref_a [NV];
    logic [15:0] ref_b [NV];

    adder_bist #(.WIDTH(16), .LATENCY(L), .NUM_VECTORS(NV), .SEED(32'hACE1_1234)) dut (
        .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o), .sum_i(sum_i),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_a  <= a_o;
        m_b  <= b_o;
        m_s1 <= {1'b0, m_a} + {1'b0, m_b};
        m_s2 <= m_s1;
    end

    assign sum_i = (mode == 1) ? {1'b0, m_s1[15:0]} : (mode == 2) ? m_s2 : m_s1;

    // Vector list: four corners, then LFSR states starting from the seed.
    task automatic build_ref();
        logic [31:0] s;
        s = 32'hACE1_1234;
        ref_a[0] = 16'h0000; ref_b[0] = 16'h0000;
        ref_a[1] = 16'hFFFF; ref_b[1] = 16'hFFFF;
        ref_a[2] = 16'hFFFF; ref_b[2] = 16'h0001;
        ref_a[3] = 16'h8000; ref_b[3] = 16'h8000;
        for (int k = 4; k < NV; k++) begin
            ref_a[k] = s[31:16];
            ref_b[k] = s[15:0];
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
    endtask

    // Predict error count and first failing index for an adder mode.
    task automatic predict(input int m, output int e_err, output int e_ffi);
        int exp_k, prev, obs;
        e_err = 0;
        e_ffi = 16'hFFFF;
        prev  = 0;
        for (int k = 0; k < NV; k++) begin
            exp_k = int'(ref_a[k]) + int'(ref_b[k]);
            if (m == 1)      obs = exp_k % 65536;
            else if (m == 2) obs = prev;
            else             obs = exp_k;
            if (obs != exp_k) begin
                if (e_err == 0) e_ffi = k;
                e_err++;
            end
            prev = exp_k;
        end
    endtask

    // One full run, checked every cycle; optional extra start pulse at cycle mid_cycle.
    task automatic run_check(input int m, input int mid_cycle, input string name);
        int e_err, e_ffi;
        logic [15:0] ea, eb;
        mode = m;
        predict(m, e_err, e_ffi);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= NV + L + 1; c++) begin
            @(negedge clk);
            start = (c == mid_cycle) ? 1'b1 : 1'b0;
            ea = (c <= NV) ? ref_a[c-1] : 16'h0;
            eb = (c <= NV) ? ref_b[c-1] : 16'h0;
            n_checks++;
            if ({a_o, b_o} !== {ea, eb}) begin
                n_fail++;
                $display("FAIL %s operands cycle %0d: got %h/%h expected %h/%h", name, c, a_o, b_o, ea, eb);
            end
            n_checks++;
            if (busy !== (c <= NV + L)) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, (c <= NV + L));
            end
            n_checks++;
            if (done !== (c == NV + L + 1)) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, (c == NV + L + 1));
            end
        end
        start = 1'b0;
        n_checks++;
        if (err_cnt !== 16'(e_err)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, e_err);
        end
        n_checks++;
        if (first_fail_idx !== 16'(e_ffi)) begin
            n_fail++;
            $display("FAIL %s first_fail_idx: got %h expected %h", name, first_fail_idx, 16'(e_ffi));
        end
        n_checks++;
        if (pass !== (e_err == 0)) begin
            n_fail++;
            $display("FAIL %s pass: got %b expected %b", name, pass, (e_err == 0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_o, b_o, busy, done, pass, err_cnt, first_fail_idx} !==
            {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset values: got a=%h b=%h busy=%b done=%b pass=%b err=%h ffi=%h expected 0/0/0/0/0/0/FFFF",
                     a_o, b_o, busy, done, pass, err_cnt, first_fail_idx);
        end
        rst = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
    endtask

    task automatic test_ideal();
        run_check(0, 0, "ideal");
    endtask

    task automatic test_stuck_bit16();
        run_check(1, 0, "stuck16");
    endtask

    task automatic test_latency3();
        run_check(2, 0, "latency3");
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if ({a_o, b_o} !== {ref_a[c-1], ref_b[c-1]}) begin
                n_fail++;
                $display("FAIL midrst operands cycle %0d: got %h/%h expected %h/%h", c, a_o, b_o, ref_a[c-1], ref_b[c-1]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_o, b_o, busy, done, pass, err_cnt, first_fail_idx} !==
            {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL midrst reset values: got a=%h b=%h busy=%b done=%b pass=%b err=%h ffi=%h expected 0/0/0/0/0/0/FFFF",
                     a_o, b_o, busy, done, pass, err_cnt, first_fail_idx);
        end
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        run_check(0, 0, "after_rst");
    endtask

    task automatic test_mid_start();
        run_check(0, int'($urandom_range(2, NV + L)), "mid_start");
    endtask

    task automatic test_back_to_back();
        run_check(0, 0, "b2b_first");
        run_check(0, 0, "b2b_second");
    endtask

    initial begin
        build_ref();
        test_reset();
        test_ideal();
        test_stuck_bit16();
        test_latency3();
        test_reset_mid_run();
        test_mid_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
